// File: rtl/bp_me_pkg.sv
// Shared types for the CCE memory-side blocks.
// Holds the command sender FSM state encoding.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_header = 2'd1,
    e_data   = 2'd2
  } bp_cce_mem_cmd_sender_state_e;

endpackage

// File: rtl/bp_cce_credit_counter.sv
// Memory-network credit counter: down on send, up on return, registered count/empty.
// Latency 1 cycle from strobe to count; a return while full is flagged and saturates.
module bp_cce_credit_counter #(
  parameter int max_credits_p = 8,
  parameter int count_width_lp = $clog2(max_credits_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      down_i,
  input  logic                      up_i,
  output logic [count_width_lp-1:0] count_o,
  output logic                      empty_o
);

  localparam logic [count_width_lp-1:0] MaxCount = count_width_lp'(max_credits_p);

  logic [count_width_lp-1:0] r_count;
  logic                      r_empty;
  logic [count_width_lp-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    case ({up_i, down_i})
      2'b10:   w_count_nxt = (r_count == MaxCount) ? r_count : r_count + count_width_lp'(1);
      2'b01:   w_count_nxt = (r_count == '0) ? r_count : r_count - count_width_lp'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= MaxCount;
      r_empty <= (max_credits_p == 0);
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

  // A return with no outstanding send means the memory side returned a credit it never had.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(up_i && !down_i && (r_count == MaxCount)))
        else $warning("credit returned while counter already at maximum");
    end
  end

  assign count_o = r_count;
  assign empty_o = r_empty;

endmodule

// File: rtl/bp_cce_mem_cmd_sender.sv
// Forwards CCE memory command headers (registered, 1 cycle) and data beats (combinational).
// Header accept is gated by credits; data ready mirrors the memory side during the data phase.
module bp_cce_mem_cmd_sender
  import bp_me_pkg::*;
#(
  parameter int header_width_p    = 128,
  parameter int data_width_p      = 64,
  parameter int max_beats_p       = 8,
  parameter int mem_max_credits_p = 8,
  parameter int beats_width_lp    = $clog2(max_beats_p + 1),
  parameter int credit_width_lp   = $clog2(mem_max_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [header_width_p-1:0]  cmd_header_i,
  input  logic [beats_width_lp-1:0]  cmd_num_beats_i,
  input  logic                       cmd_header_v_i,
  output logic                       cmd_header_ready_and_o,
  input  logic [data_width_p-1:0]    cmd_data_i,
  input  logic                       cmd_data_v_i,
  output logic                       cmd_data_ready_and_o,
  output logic [header_width_p-1:0]  mem_cmd_header_o,
  output logic                       mem_cmd_header_v_o,
  input  logic                       mem_cmd_header_ready_and_i,
  output logic [data_width_p-1:0]    mem_cmd_data_o,
  output logic                       mem_cmd_data_v_o,
  input  logic                       mem_cmd_data_ready_and_i,
  input  logic                       mem_resp_yumi_i,
  output logic [credit_width_lp-1:0] credit_count_o,
  output logic                       credits_empty_o
);

  bp_cce_mem_cmd_sender_state_e r_state, w_state_nxt;
  logic [header_width_p-1:0]    r_header;
  logic [beats_width_lp-1:0]    r_num_beats;
  logic [beats_width_lp-1:0]    r_beat_cnt;
  logic                         w_hdr_accept;
  logic                         w_send;
  logic                         w_beat_accept;
  logic                         w_credits_empty;

  bp_cce_credit_counter #(
    .max_credits_p(mem_max_credits_p)
  ) u_credits (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .down_i   (w_send),
    .up_i     (mem_resp_yumi_i),
    .count_o  (credit_count_o),
    .empty_o  (w_credits_empty)
  );

  always_comb begin
    w_state_nxt            = r_state;
    cmd_header_ready_and_o = 1'b0;
    mem_cmd_header_v_o     = 1'b0;
    mem_cmd_data_v_o       = 1'b0;
    cmd_data_ready_and_o   = 1'b0;
    w_hdr_accept           = 1'b0;
    w_send                 = 1'b0;
    w_beat_accept          = 1'b0;
    case (r_state)
      e_idle: begin
        cmd_header_ready_and_o = ~w_credits_empty;
        w_hdr_accept           = cmd_header_v_i & ~w_credits_empty;
        if (w_hdr_accept) w_state_nxt = e_header;
      end
      e_header: begin
        mem_cmd_header_v_o = 1'b1;
        w_send             = mem_cmd_header_ready_and_i;
        if (w_send) w_state_nxt = (r_num_beats == '0) ? e_idle : e_data;
      end
      e_data: begin
        mem_cmd_data_v_o     = cmd_data_v_i;
        cmd_data_ready_and_o = mem_cmd_data_ready_and_i;
        w_beat_accept        = cmd_data_v_i & mem_cmd_data_ready_and_i;
        // Compare against count+1 so a zero beat count can never underflow here.
        if (w_beat_accept && ((r_beat_cnt + beats_width_lp'(1)) == r_num_beats))
          w_state_nxt = e_idle;
      end
      default: w_state_nxt = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_idle;
      r_header    <= '0;
      r_num_beats <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hdr_accept) begin
        r_header    <= cmd_header_i;
        r_num_beats <= cmd_num_beats_i;
      end
      if (w_send)             r_beat_cnt <= '0;
      else if (w_beat_accept) r_beat_cnt <= r_beat_cnt + beats_width_lp'(1);
    end
  end

  assign mem_cmd_header_o = r_header;
  assign mem_cmd_data_o   = cmd_data_i;
  assign credits_empty_o  = w_credits_empty;

endmodule
